// File: rtl/ibex_multdiv_issue.sv
// Issue-side controller for the slow multiply/divide unit: holds the request,
// drives unit enables/selects, owns the intermediate registers and the result.
package ibex_pkg;
   typedef enum logic [1:0] {
      MD_OP_MULL,
      MD_OP_MULH,
      MD_OP_DIV,
      MD_OP_REM
   } md_op_e;
endpackage

module ibex_multdiv_issue #(
   parameter int unsigned WatchdogCycles = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  ibex_pkg::md_op_e         req_operator_i,
   input  logic [1:0]               req_signed_mode_i,
   input  logic [31:0]              req_op_a_i,
   input  logic [31:0]              req_op_b_i,
   input  logic                     req_data_ind_timing_i,
   input  logic                     kill_i,
   output logic                     mult_en_o,
   output logic                     div_en_o,
   output logic                     mult_sel_o,
   output logic                     div_sel_o,
   output ibex_pkg::md_op_e         operator_o,
   output logic [1:0]               signed_mode_o,
   output logic [31:0]              op_a_o,
   output logic [31:0]              op_b_o,
   output logic                     data_ind_timing_o,
   output logic [33:0]              imd_val_q_o [2],
   input  logic [33:0]              imd_val_d_i [2],
   input  logic [1:0]               imd_val_we_i,
   input  logic                     md_valid_i,
   input  logic [31:0]              md_result_i,
   output logic                     multdiv_ready_id_o,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [31:0]              res_data_o,
   output logic                     watchdog_err_o
);

   // state  | meaning
   // IDLE   | waiting for a request, req_ready_o high
   // BUSY   | unit enabled and iterating, watchdog counting
   // DONE   | result held for writeback
   // ABORT  | single enables-low cycle that resets the unit's own FSM
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ABORT} state_e;

   state_e            state_q, state_d;
   logic              accept;
   logic              wdog_hit;
   logic              err_d, err_q;
   logic [7:0]        cnt_q;
   logic              is_mult_q;
   ibex_pkg::md_op_e  operator_q;
   logic [1:0]        signed_mode_q;
   logic [31:0]       op_a_q, op_b_q;
   logic              dit_q;
   logic [31:0]       res_q;
   logic [33:0]       imd_q [2];

   assign wdog_hit = (cnt_q == 8'(WatchdogCycles - 1));

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i && !kill_i) begin
               state_d = S_BUSY;
               accept  = 1'b1;
            end
         end
         S_BUSY: begin
            // kill beats a coincident result; a result beats the watchdog
            if (kill_i) begin
               state_d = S_ABORT;
            end else if (md_valid_i) begin
               state_d = S_DONE;
            end else if (wdog_hit) begin
               state_d = S_ABORT;
               err_d   = 1'b1;
            end
         end
         S_DONE: begin
            if (kill_i || res_ready_i) state_d = S_IDLE;
         end
         S_ABORT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         err_q         <= 1'b0;
         cnt_q         <= 8'd0;
         is_mult_q     <= 1'b0;
         operator_q    <= ibex_pkg::MD_OP_MULL;
         signed_mode_q <= 2'b00;
         op_a_q        <= 32'd0;
         op_b_q        <= 32'd0;
         dit_q         <= 1'b0;
         res_q         <= 32'd0;
         imd_q[0]      <= 34'd0;
         imd_q[1]      <= 34'd0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (accept) begin
            operator_q    <= req_operator_i;
            signed_mode_q <= req_signed_mode_i;
            op_a_q        <= req_op_a_i;
            op_b_q        <= req_op_b_i;
            dit_q         <= req_data_ind_timing_i;
            is_mult_q     <= (req_operator_i == ibex_pkg::MD_OP_MULL) ||
                             (req_operator_i == ibex_pkg::MD_OP_MULH);
            cnt_q         <= 8'd0;
            imd_q[0]      <= 34'd0;
            imd_q[1]      <= 34'd0;
         end else if (state_q == S_BUSY) begin
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            for (int i = 0; i < 2; i++) begin
               if (imd_val_we_i[i]) imd_q[i] <= imd_val_d_i[i];
            end
         end
         if (state_q == S_BUSY && state_d == S_DONE) res_q <= md_result_i;
      end
   end

   assign req_ready_o        = (state_q == S_IDLE);
   assign multdiv_ready_id_o = (state_q == S_BUSY);
   assign mult_en_o          = (state_q == S_BUSY) &&  is_mult_q;
   assign div_en_o           = (state_q == S_BUSY) && !is_mult_q;
   assign mult_sel_o         = (state_q == S_BUSY || state_q == S_DONE) &&  is_mult_q;
   assign div_sel_o          = (state_q == S_BUSY || state_q == S_DONE) && !is_mult_q;
   assign res_valid_o        = (state_q == S_DONE);
   assign res_data_o         = res_q;
   assign watchdog_err_o     = err_q;
   assign operator_o         = operator_q;
   assign signed_mode_o      = signed_mode_q;
   assign op_a_o             = op_a_q;
   assign op_b_o             = op_b_q;
   assign data_ind_timing_o  = dit_q;
   assign imd_val_q_o[0]     = imd_q[0];
   assign imd_val_q_o[1]     = imd_q[1];

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Bench for ibex_multdiv_issue: a behavioural multdiv unit answers requests and
// results, enable windows and intermediate registers are checked against it.
module tb_ibex_multdiv_issue;
   import ibex_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   md_op_e      req_operator_i;
   logic [1:0]  req_signed_mode_i;
   logic [31:0] req_op_a_i, req_op_b_i;
   logic        req_data_ind_timing_i;
   logic        kill_i;
   logic        mult_en_o, div_en_o, mult_sel_o, div_sel_o;
   md_op_e      operator_o;
   logic [1:0]  signed_mode_o;
   logic [31:0] op_a_o, op_b_o;
   logic        data_ind_timing_o;
   logic [33:0] imd_val_q_o [2];
   logic [33:0] imd_val_d_i [2];
   logic [1:0]  imd_val_we_i;
   logic        md_valid_i;
   logic [31:0] md_result_i;
   logic        multdiv_ready_id_o;
   logic        res_valid_o;
   logic        res_ready_i;
   logic [31:0] res_data_o;
   logic        watchdog_err_o;

   int n_assert = 0;
   int n_fail   = 0;

   ibex_multdiv_issue #(.WatchdogCycles(64)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_operator_i(req_operator_i), .req_signed_mode_i(req_signed_mode_i),
      .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
      .req_data_ind_timing_i(req_data_ind_timing_i), .kill_i(kill_i),
      .mult_en_o(mult_en_o), .div_en_o(div_en_o),
      .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
      .operator_o(operator_o), .signed_mode_o(signed_mode_o),
      .op_a_o(op_a_o), .op_b_o(op_b_o), .data_ind_timing_o(data_ind_timing_o),
      .imd_val_q_o(imd_val_q_o), .imd_val_d_i(imd_val_d_i), .imd_val_we_i(imd_val_we_i),
      .md_valid_i(md_valid_i), .md_result_i(md_result_i),
      .multdiv_ready_id_o(multdiv_ready_id_o),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
      .watchdog_err_o(watchdog_err_o)
   );

   always #5 clk_i = ~clk_i;

   // RISC-V M-extension semantics; division is signed when both operands are.
   function automatic logic [31:0] ref_md(input md_op_e op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
      logic signed [65:0] pa, pb, prod;
      logic signed [31:0] sa, sb;
      logic               sdiv, ovf;
      pa   = {{34{sm[0] & a[31]}}, a};
      pb   = {{34{sm[1] & b[31]}}, b};
      prod = pa * pb;
      sa   = a;
      sb   = b;
      sdiv = (sm == 2'b11);
      ovf  = sdiv && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         MD_OP_MULL: return prod[31:0];
         MD_OP_MULH: return prod[63:32];
         MD_OP_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            if (sdiv) return sa / sb;
            return a / b;
         end
         default: begin
            if (b == 32'd0) return a;
            if (ovf) return 32'd0;
            if (sdiv) return sa % sb;
            return a % b;
         end
      endcase
   endfunction

   task automatic issue(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                        input logic [31:0] b, input logic dit);
      req_valid_i           = 1'b1;
      req_operator_i        = op;
      req_signed_mode_i     = sm;
      req_op_a_i            = a;
      req_op_b_i            = b;
      req_data_ind_timing_i = dit;
      @(negedge clk_i);
      req_valid_i           = 1'b0;
   endtask

   // Unit model: answers in the lat-th BUSY cycle; leaves the bench in DONE.
   task automatic run_op(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                         input logic [31:0] b, input logic dit, input int lat,
                         output int mcnt, output int dcnt);
      mcnt = 0;
      dcnt = 0;
      issue(op, sm, a, b, dit);
      for (int k = 1; k <= lat; k++) begin
         if (mult_en_o) mcnt++;
         if (div_en_o) dcnt++;
         if (k == lat) begin
            md_valid_i  = 1'b1;
            md_result_i = ref_md(op, sm, a, b);
         end
         @(negedge clk_i);
      end
      md_valid_i  = 1'b0;
      md_result_i = 32'd0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      n_assert++;
      if (req_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %0b want 1", req_ready_o);
      end
      n_assert++;
      if ({mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o, res_valid_o,
           watchdog_err_o, data_ind_timing_o} !== 8'd0) begin
         n_fail++; $display("FAIL reset_bits: got %b want 00000000",
            {mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o, res_valid_o,
             watchdog_err_o, data_ind_timing_o});
      end
      n_assert++;
      if ({operator_o, signed_mode_o, op_a_o, op_b_o, res_data_o} !== 100'd0) begin
         n_fail++; $display("FAIL reset_data: got a=%h b=%h res=%h want 0", op_a_o, op_b_o, res_data_o);
      end
      n_assert++;
      if ({imd_val_q_o[0], imd_val_q_o[1]} !== 68'd0) begin
         n_fail++; $display("FAIL reset_imd: got %h %h want 0", imd_val_q_o[0], imd_val_q_o[1]);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_mull();
      int mc, dc;
      run_op(MD_OP_MULL, 2'b11, 32'd7, 32'hFFFF_FFFD, 1'b0, 34, mc, dc);
      n_assert++;
      if (mc != 34 || dc != 0) begin
         n_fail++; $display("FAIL mull_en_cycles: got mult=%0d div=%0d want 34/0", mc, dc);
      end
      n_assert++;
      if ({mult_en_o, div_en_o, mult_sel_o, div_sel_o} !== 4'b0010) begin
         n_fail++; $display("FAIL mull_done_ctrl: got %b want 0010",
            {mult_en_o, div_en_o, mult_sel_o, div_sel_o});
      end
      res_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_assert++;
         if (res_valid_o !== 1'b1 || res_data_o !== 32'hFFFF_FFEB) begin
            n_fail++; $display("FAIL mull_hold: got v=%0b d=%h want 1 ffffffeb", res_valid_o, res_data_o);
         end
         @(negedge clk_i);
      end
      res_ready_i = 1'b1;
      @(negedge clk_i);
      res_ready_i = 1'b0;
      n_assert++;
      if (req_ready_o !== 1'b1 || res_valid_o !== 1'b0 || mult_sel_o !== 1'b0) begin
         n_fail++; $display("FAIL mull_release: got rdy=%0b v=%0b sel=%0b want 1 0 0",
            req_ready_o, res_valid_o, mult_sel_o);
      end
   endtask

   task automatic test_div();
      logic [33:0] exp0, exp1, d0, d1;
      logic [1:0]  we;
      exp0 = 34'd0;
      exp1 = 34'd0;
      imd_val_we_i = 2'b11;
      for (int i = 0; i < 2; i++) begin
         imd_val_d_i[0] = {$urandom, 2'($urandom)};
         imd_val_d_i[1] = {$urandom, 2'($urandom)};
         @(negedge clk_i);
         n_assert++;
         if (imd_val_q_o[0] !== exp0 || imd_val_q_o[1] !== exp1) begin
            n_fail++; $display("FAIL div_imd_idle: got %h %h want %h %h",
               imd_val_q_o[0], imd_val_q_o[1], exp0, exp1);
         end
      end
      issue(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         n_assert++;
         if (imd_val_q_o[0] !== exp0 || imd_val_q_o[1] !== exp1) begin
            n_fail++; $display("FAIL div_imd_busy: cyc %0d got %h %h want %h %h",
               k, imd_val_q_o[0], imd_val_q_o[1], exp0, exp1);
         end
         we = 2'($urandom);
         d0 = {$urandom, 2'($urandom)};
         d1 = {$urandom, 2'($urandom)};
         imd_val_we_i   = we;
         imd_val_d_i[0] = d0;
         imd_val_d_i[1] = d1;
         if (we[0]) exp0 = d0;
         if (we[1]) exp1 = d1;
         if (k == 20) begin
            md_valid_i  = 1'b1;
            md_result_i = ref_md(MD_OP_DIV, 2'b00, 32'd100, 32'd7);
         end
         @(negedge clk_i);
      end
      md_valid_i   = 1'b0;
      imd_val_we_i = 2'b11;
      imd_val_d_i[0] = ~exp0;
      imd_val_d_i[1] = ~exp1;
      n_assert++;
      if (imd_val_q_o[0] !== exp0 || imd_val_q_o[1] !== exp1) begin
         n_fail++; $display("FAIL div_imd_last: got %h %h want %h %h",
            imd_val_q_o[0], imd_val_q_o[1], exp0, exp1);
      end
      @(negedge clk_i);
      imd_val_we_i = 2'b00;
      n_assert++;
      if (imd_val_q_o[0] !== exp0 || imd_val_q_o[1] !== exp1) begin
         n_fail++; $display("FAIL div_imd_done: got %h %h want %h %h",
            imd_val_q_o[0], imd_val_q_o[1], exp0, exp1);
      end
      n_assert++;
      if (res_valid_o !== 1'b1 || res_data_o !== 32'd14 || div_sel_o !== 1'b1 ||
          data_ind_timing_o !== 1'b1) begin
         n_fail++; $display("FAIL div_result: got v=%0b d=%0d sel=%0b dit=%0b want 1 14 1 1",
            res_valid_o, res_data_o, div_sel_o, data_ind_timing_o);
      end
      res_ready_i = 1'b1;
      @(negedge clk_i);
      res_ready_i = 1'b0;
   endtask

   task automatic test_kill_busy();
      int          mc, dc;
      logic [31:0] a, b;
      issue(MD_OP_REM, 2'b11, 32'd55, 32'd4, 1'b0);
      repeat (4) @(negedge clk_i);
      n_assert++;
      if (div_en_o !== 1'b1) begin
         n_fail++; $display("FAIL kill_pre: got div_en=%0b want 1", div_en_o);
      end
      kill_i = 1'b1;
      @(negedge clk_i);
      kill_i = 1'b0;
      n_assert++;
      if ({mult_en_o, div_en_o, mult_sel_o, div_sel_o, res_valid_o, req_ready_o,
           watchdog_err_o, multdiv_ready_id_o} !== 8'd0) begin
         n_fail++; $display("FAIL kill_abort: got %b want 00000000",
            {mult_en_o, div_en_o, mult_sel_o, div_sel_o, res_valid_o, req_ready_o,
             watchdog_err_o, multdiv_ready_id_o});
      end
      @(negedge clk_i);
      n_assert++;
      if (req_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL kill_idle: got rdy=%0b v=%0b want 1 0", req_ready_o, res_valid_o);
      end
      a = $urandom;
      b = $urandom;
      run_op(MD_OP_MULH, 2'b01, a, b, 1'b0, 9, mc, dc);
      n_assert++;
      if (mc != 9 || dc != 0 || res_valid_o !== 1'b1 ||
          res_data_o !== ref_md(MD_OP_MULH, 2'b01, a, b)) begin
         n_fail++; $display("FAIL kill_next: got m=%0d d=%0d v=%0b res=%h want 9 0 1 %h",
            mc, dc, res_valid_o, res_data_o, ref_md(MD_OP_MULH, 2'b01, a, b));
      end
      res_ready_i = 1'b1;
      @(negedge clk_i);
      res_ready_i = 1'b0;
   endtask

   task automatic test_watchdog();
      int   cnt   = 0;
      int   guard = 0;
      logic err_seen = 1'b0;
      issue(MD_OP_DIV, 2'b11, $urandom, $urandom, 1'b0);
      while ((mult_en_o || div_en_o) && guard < 300) begin
         cnt++;
         if (watchdog_err_o) err_seen = 1'b1;
         @(negedge clk_i);
         guard++;
      end
      n_assert++;
      if (cnt != 64 || err_seen !== 1'b0) begin
         n_fail++; $display("FAIL wdog_busy_len: got %0d early_err=%0b want 64 0", cnt, err_seen);
      end
      n_assert++;
      if (watchdog_err_o !== 1'b1 || req_ready_o !== 1'b0 || res_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL wdog_pulse: got err=%0b rdy=%0b v=%0b want 1 0 0",
            watchdog_err_o, req_ready_o, res_valid_o);
      end
      @(negedge clk_i);
      n_assert++;
      if (watchdog_err_o !== 1'b0 || req_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL wdog_idle: got err=%0b rdy=%0b want 0 1", watchdog_err_o, req_ready_o);
      end
   endtask

   task automatic test_wdog_boundary();
      int          mc, dc;
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      run_op(MD_OP_MULL, 2'b00, a, b, 1'b0, 64, mc, dc);
      n_assert++;
      if (mc != 64 || res_valid_o !== 1'b1 || watchdog_err_o !== 1'b0 ||
          res_data_o !== a * b) begin
         n_fail++; $display("FAIL wdog_limit_result: got m=%0d v=%0b err=%0b res=%h want 64 1 0 %h",
            mc, res_valid_o, watchdog_err_o, res_data_o, a * b);
      end
      res_ready_i = 1'b1;
      @(negedge clk_i);
      res_ready_i = 1'b0;
   endtask

   task automatic test_valid_kill();
      issue(MD_OP_MULL, 2'b11, $urandom, $urandom, 1'b0);
      repeat (2) @(negedge clk_i);
      md_valid_i  = 1'b1;
      md_result_i = $urandom;
      kill_i      = 1'b1;
      @(negedge clk_i);
      md_valid_i  = 1'b0;
      kill_i      = 1'b0;
      n_assert++;
      if ({res_valid_o, req_ready_o, mult_en_o, mult_sel_o, watchdog_err_o} !== 5'd0) begin
         n_fail++; $display("FAIL vk_abort: got v=%0b rdy=%0b en=%0b sel=%0b err=%0b want all 0",
            res_valid_o, req_ready_o, mult_en_o, mult_sel_o, watchdog_err_o);
      end
      @(negedge clk_i);
      n_assert++;
      if (req_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL vk_idle: got rdy=%0b v=%0b want 1 0", req_ready_o, res_valid_o);
      end
   endtask

   task automatic test_kill_idle_done();
      int mc, dc;
      req_valid_i = 1'b1;
      kill_i      = 1'b1;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      kill_i      = 1'b0;
      n_assert++;
      if (req_ready_o !== 1'b1 || mult_en_o !== 1'b0 || div_en_o !== 1'b0) begin
         n_fail++; $display("FAIL kill_in_idle: got rdy=%0b en=%0b%0b want 1 00",
            req_ready_o, mult_en_o, div_en_o);
      end
      run_op(MD_OP_REM, 2'b00, 32'd17, 32'd5, 1'b0, 4, mc, dc);
      kill_i = 1'b1;
      @(negedge clk_i);
      kill_i = 1'b0;
      n_assert++;
      if (res_valid_o !== 1'b0 || req_ready_o !== 1'b1 || div_sel_o !== 1'b0) begin
         n_fail++; $display("FAIL kill_in_done: got v=%0b rdy=%0b sel=%0b want 0 1 0",
            res_valid_o, req_ready_o, div_sel_o);
      end
   endtask

   task automatic test_back_to_back();
      int mc, dc;
      run_op(MD_OP_DIV, 2'b11, 32'hFFFF_FF9C, 32'd7, 1'b0, 3, mc, dc);
      res_ready_i           = 1'b1;
      req_valid_i           = 1'b1;
      req_operator_i        = MD_OP_MULL;
      req_signed_mode_i     = 2'b00;
      req_op_a_i            = 32'd12;
      req_op_b_i            = 32'd11;
      req_data_ind_timing_i = 1'b0;
      @(negedge clk_i);
      res_ready_i = 1'b0;
      n_assert++;
      if (req_ready_o !== 1'b1 || res_valid_o !== 1'b0 || mult_en_o !== 1'b0 || div_en_o !== 1'b0) begin
         n_fail++; $display("FAIL b2b_no_accept: got rdy=%0b v=%0b en=%0b%0b want 1 0 00",
            req_ready_o, res_valid_o, mult_en_o, div_en_o);
      end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      n_assert++;
      if (mult_en_o !== 1'b1 || multdiv_ready_id_o !== 1'b1 || op_a_o !== 32'd12) begin
         n_fail++; $display("FAIL b2b_accept: got en=%0b rid=%0b a=%0d want 1 1 12",
            mult_en_o, multdiv_ready_id_o, op_a_o);
      end
      md_valid_i  = 1'b1;
      md_result_i = ref_md(MD_OP_MULL, 2'b00, 32'd12, 32'd11);
      @(negedge clk_i);
      md_valid_i  = 1'b0;
      n_assert++;
      if (res_valid_o !== 1'b1 || res_data_o !== 32'd132) begin
         n_fail++; $display("FAIL b2b_result: got v=%0b d=%0d want 1 132", res_valid_o, res_data_o);
      end
      res_ready_i = 1'b1;
      @(negedge clk_i);
      res_ready_i = 1'b0;
   endtask

   task automatic test_random_ops();
      md_op_e      op;
      logic [1:0]  sm;
      logic [31:0] a, b, exp;
      logic        mul, dit;
      int          lat, stall, mc, dc;
      for (int t = 0; t < 12; t++) begin
         op    = md_op_e'($urandom_range(0, 3));
         mul   = (op == MD_OP_MULL) || (op == MD_OP_MULH);
         sm    = mul ? 2'($urandom_range(0, 3)) : ($urandom_range(0, 1) == 1 ? 2'b11 : 2'b00);
         a     = $urandom;
         b     = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         dit   = 1'($urandom_range(0, 1));
         lat   = $urandom_range(1, 40);
         stall = $urandom_range(0, 3);
         exp   = ref_md(op, sm, a, b);
         run_op(op, sm, a, b, dit, lat, mc, dc);
         n_assert++;
         if (mc != (mul ? lat : 0) || dc != (mul ? 0 : lat)) begin
            n_fail++; $display("FAIL rnd_en_count: op%0d got m=%0d d=%0d lat=%0d mul=%0b",
               t, mc, dc, lat, mul);
         end
         n_assert++;
         if ({mult_en_o, div_en_o, mult_sel_o, div_sel_o} !== {2'b00, mul, !mul}) begin
            n_fail++; $display("FAIL rnd_done_ctrl: op%0d got %b want %b", t,
               {mult_en_o, div_en_o, mult_sel_o, div_sel_o}, {2'b00, mul, !mul});
         end
         n_assert++;
         if (operator_o !== op || signed_mode_o !== sm || op_a_o !== a || op_b_o !== b ||
             data_ind_timing_o !== dit) begin
            n_fail++; $display("FAIL rnd_fields: op%0d got %0d %b %h %h %0b want %0d %b %h %h %0b", t,
               operator_o, signed_mode_o, op_a_o, op_b_o, data_ind_timing_o, op, sm, a, b, dit);
         end
         for (int s = 0; s <= stall; s++) begin
            n_assert++;
            if (res_valid_o !== 1'b1 || res_data_o !== exp) begin
               n_fail++; $display("FAIL rnd_result: op%0d got v=%0b d=%h want 1 %h",
                  t, res_valid_o, res_data_o, exp);
            end
            if (s < stall) @(negedge clk_i);
         end
         res_ready_i = 1'b1;
         @(negedge clk_i);
         res_ready_i = 1'b0;
         n_assert++;
         if (req_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rnd_release: op%0d got rdy=%0b v=%0b want 1 0",
               t, req_ready_o, res_valid_o);
         end
      end
   endtask

   task automatic test_reset_done();
      issue(MD_OP_MULH, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
      imd_val_we_i = 2'b11;
      for (int k = 1; k <= 6; k++) begin
         imd_val_d_i[0] = {$urandom, 2'b01};
         imd_val_d_i[1] = {$urandom, 2'b10};
         if (k == 6) begin
            md_valid_i  = 1'b1;
            md_result_i = 32'hCAFE_F00D;
         end
         @(negedge clk_i);
      end
      md_valid_i   = 1'b0;
      imd_val_we_i = 2'b00;
      n_assert++;
      if (res_valid_o !== 1'b1 || res_data_o !== 32'hCAFE_F00D) begin
         n_fail++; $display("FAIL rstd_pre: got v=%0b d=%h want 1 cafef00d", res_valid_o, res_data_o);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      n_assert++;
      if ({req_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o,
           res_valid_o, watchdog_err_o, data_ind_timing_o} !== 9'b1_0000_0000) begin
         n_fail++; $display("FAIL rstd_bits: got %b want 100000000",
            {req_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o,
             res_valid_o, watchdog_err_o, data_ind_timing_o});
      end
      n_assert++;
      if ({operator_o, signed_mode_o, op_a_o, op_b_o, res_data_o,
           imd_val_q_o[0], imd_val_q_o[1]} !== 168'd0) begin
         n_fail++; $display("FAIL rstd_data: got a=%h b=%h res=%h imd=%h %h want 0",
            op_a_o, op_b_o, res_data_o, imd_val_q_o[0], imd_val_q_o[1]);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      n_assert++;
      if (req_ready_o !== 1'b1 || watchdog_err_o !== 1'b0 || res_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL rstd_after: got rdy=%0b err=%0b v=%0b want 1 0 0",
            req_ready_o, watchdog_err_o, res_valid_o);
      end
   endtask

   initial begin
      rst_i                 = 1'b1;
      req_valid_i           = 1'b0;
      req_operator_i        = MD_OP_MULL;
      req_signed_mode_i     = 2'b00;
      req_op_a_i            = 32'd0;
      req_op_b_i            = 32'd0;
      req_data_ind_timing_i = 1'b0;
      kill_i                = 1'b0;
      imd_val_d_i[0]        = 34'd0;
      imd_val_d_i[1]        = 34'd0;
      imd_val_we_i          = 2'b00;
      md_valid_i            = 1'b0;
      md_result_i           = 32'd0;
      res_ready_i           = 1'b0;
      @(negedge clk_i);
      test_reset();
      test_mull();
      test_div();
      test_kill_busy();
      test_watchdog();
      test_wdog_boundary();
      test_valid_kill();
      test_kill_idle_done();
      test_back_to_back();
      test_random_ops();
      test_reset_done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ibex_multdiv_issue.md
# ibex_multdiv_issue

Requester-side controller for the slow multiply/divide unit. It accepts one decoded MULT/DIV operation per handshake, registers the operands and holds them stable, and drives the unit's dynamic enables and static selects. It owns the two 34-bit intermediate-value registers the unit iterates on, captures the result when the unit signals valid, and presents that result to writeback on a valid/ready handshake. It sits in the ID stage between the decoder and the multdiv unit, and also handles flush and watchdog abort.

## Interface
- WatchdogCycles, default 64: number of BUSY cycles after which the operation is aborted. Range 40..255.
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  decoded multdiv operation present.
- req_ready_o  out  1  block is able to accept an operation.
- req_operator_i  in  ibex_pkg::md_op_e  MULL/MULH/DIV/REM.
- req_signed_mode_i  in  2  signedness of {op_b, op_a}.
- req_op_a_i, req_op_b_i  in  32 each  source operands.
- req_data_ind_timing_i  in  1  data-independent timing mode.
- kill_i  in  1  flush; abandons any in-flight operation.
- mult_en_o, div_en_o  out  1 each  dynamic enables to the unit.
- mult_sel_o, div_sel_o  out  1 each  static selects to the unit.
- operator_o, signed_mode_o, op_a_o, op_b_o, data_ind_timing_o  out  registered copies of the request fields.
- imd_val_q_o  out  34 x2  intermediate registers, fed to the unit.
- imd_val_d_i  in  34 x2  next intermediate values from the unit.
- imd_val_we_i  in  2  per-register write enable from the unit.
- md_valid_i  in  1  the unit's result is valid.
- md_result_i  in  32  the unit's result.
- multdiv_ready_id_o  out  1  this block is ready to take the unit's result.
- res_valid_o  out  1  captured result available for writeback.
- res_ready_i  in  1  writeback accepts the result.
- res_data_o  out  32  captured result.
- watchdog_err_o  out  1  one-cycle pulse when the watchdog aborts an operation.

## Operation
- States:
  - IDLE: req_ready_o=1.
  - BUSY: enables asserted; cycle counter running.
  - DONE: result held for writeback.
  - ABORT: exactly one cycle; all enables low.
- IDLE -> BUSY on req_valid_i & req_ready_o & !kill_i.
  - Register operator, signed mode, operands and timing mode.
  - is_mult = operator in {MULL, MULH}.
  - Clear the counter.
- BUSY outputs:
  - mult_en_o = is_mult; div_en_o = !is_mult.
  - mult_sel_o/div_sel_o follow the same rule and are held in BUSY and DONE. They are 0 in IDLE and ABORT.
  - multdiv_ready_id_o = 1 in BUSY only.
- BUSY -> DONE on md_valid_i: capture md_result_i into res_data_o.
- BUSY -> ABORT on either:
  - kill_i; or
  - counter == WatchdogCycles-1 without md_valid_i. This also pulses watchdog_err_o.
- DONE: res_valid_o=1 and all enables low. DONE -> IDLE on res_ready_i.
- ABORT -> IDLE unconditionally. The 1-cycle enable-low gap resets the unit's FSM.
- Kill in DONE: drop the result (no res handshake) and go to IDLE.
- Kill in IDLE: blocks acceptance in that cycle.
- imd_val_q[i] <= imd_val_d_i[i] when imd_val_we_i[i] is set, in BUSY only; writes in any other state are ignored. Both registers are cleared on entry to BUSY.
- Simultaneous events:
  - md_valid_i with kill_i: kill wins, go to ABORT.
  - md_valid_i on the watchdog-limit cycle: the result wins, go to DONE, no error.
- Counter: 8-bit, saturating, increments every BUSY cycle.

## Timing
- Reset values:
  - State IDLE.
  - All data/operand outputs, imd_val_q and res_data_o are 0.
  - req_ready_o=1; every other 1-bit output is 0.
- Request accepted at cycle N: enables high from N+1.
- md_valid_i at cycle M: res_valid_o high at M+1.
- Minimum request-to-result latency is 2 cycles plus the unit's latency.
- res_valid_o and res_data_o stay stable until res_ready_i.
- Handshake at cycle K: req_ready_o is high at K+1. There is no back-to-back acceptance in DONE.
- Reset mid-operation returns to IDLE in the next cycle with no result and no error pulse.
- All outputs are registered or derived only from state and registered data; no input-to-output combinational path.

## Test plan
- MULL: a=7, b=-3, signed_mode=2'b11, with the unit model answering after 34 cycles.
  - res_data_o=32'hFFFFFFEB.
  - mult_en_o high for exactly 34 cycles.
  - res_valid_o held through 3 cycles of res_ready_i=0.
- DIV: a=100, b=7, unsigned. imd_val_we_i toggled by the model.
  - imd_val_q tracks imd_val_d_i only on we cycles.
  - res_data_o=14.
- kill_i in BUSY cycle 5:
  - One ABORT cycle with both enables low, then IDLE.
  - No res_valid_o.
  - The next request completes normally.
- Model never asserts md_valid_i, WatchdogCycles=64:
  - watchdog_err_o pulses at BUSY cycle 64.
  - IDLE two cycles later.
- md_valid_i coincident with kill_i: no result is produced and the state goes to ABORT.
- rst_i asserted in DONE: all outputs return to their reset values at the next edge.
